// File: rtl/capture_unit.sv
// capture_unit: timestamps rising edges of an async event against a
// free-running count and queues {count, delta} entries for a consumer.
module capture_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_count,
  output logic [WIDTH-1:0]         out_delta,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] dlt;
  } ent_t;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          h_q, h_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] last_cap_q, last_cap_d;
  logic          ovf_q, ovf_d;
  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];

  logic          cap_req;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  ent_t          head;

  // Synchronizer chain plus history flop for rising-edge detection
  always_comb begin
    s1_d    = event_in;
    s2_d    = s1_q;
    h_d     = s2_q;
    cap_req = s2_q & ~h_q;
  end

  // FIFO status and push/pop/drop decisions
  always_comb begin
    wr_idx = wr_ptr_q[AW-1:0];
    rd_idx = rd_ptr_q[AW-1:0];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
             (wr_idx == rd_idx);
    pop    = ~empty & out_ready;
    push   = cap_req & (~full | pop);
    drop   = cap_req & full & ~pop;
  end

  // Next-state for pointers, last capture, overflow and storage
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_idx].cnt = count_in;
      mem_d[wr_idx].dlt = count_in - last_cap_q;
    end
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    last_cap_d = push ? count_in : last_cap_q;
    ovf_d      = (ovf_q & ~clear_ovf) | drop;
  end

  // Control state; sync flops reset high so a held event is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      h_q        <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_cap_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      h_q        <= h_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_cap_q <= last_cap_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage; contents are only observable through valid pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head entry and status outputs
  always_comb begin
    head      = mem_q[rd_idx];
    out_valid = ~empty;
    out_count = head.cnt;
    out_delta = head.dlt;
    overflow  = ovf_q;
    level     = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: tb/tb_capture_unit.sv
// tb_capture_unit: directed scenarios plus random traffic, checked
// against a queue-based reference model of the capture behaviour.
module tb_capture_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] count_in;
  logic             event_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic [WIDTH-1:0] out_delta;
  logic             overflow;
  logic             clear_ovf;
  logic [2:0]       level;

  capture_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .event_in  (event_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_delta (out_delta),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf;
  logic             ev1, ev2, ev3;
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Event sampled high at edge n (low at n-1) is captured at edge n+2.
  task automatic model_edge();
    logic push, pop, full;
    ent_t e;
    if (reset) begin
      q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      ev1 = 1'b1; ev2 = 1'b1; ev3 = 1'b1;
    end else begin
      push = ev2 & ~ev3;
      pop  = (q.size() != 0) && out_ready;
      full = (q.size() == DEPTH);
      if (clear_ovf) m_ovf = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (full && !pop) m_ovf = 1'b1;
        else begin
          e.c = count_in;
          e.d = count_in - m_last;
          q.push_back(e);
          m_last = count_in;
        end
      end
      ev3 = ev2; ev2 = ev1; ev1 = event_in;
    end
  endtask

  task automatic step(input logic rst, input logic ev,
                      input logic rdy, input logic clr,
                      input logic [WIDTH-1:0] cnt);
    @(negedge clk);
    reset     = rst;
    event_in  = ev;
    out_ready = rdy;
    clear_ovf = clr;
    count_in  = cnt;
    @(posedge clk);
    model_edge();
    #1;
    check("valid", out_valid, q.size() != 0);
    check("level", level, q.size());
    check("ovf", overflow, m_ovf);
    if (q.size() != 0) begin
      check("count", out_count, q[0].c);
      check("delta", out_delta, q[0].d);
    end
  endtask

  logic [WIDTH-1:0] rc;

  initial begin
    reset = 1'b1; event_in = 1'b0; out_ready = 1'b0;
    clear_ovf = 1'b0; count_in = '0;
    m_last = '0; m_ovf = 1'b0;
    ev1 = 1'b1; ev2 = 1'b1; ev3 = 1'b1;

    // single event: rises before count 10, captured at 12
    repeat (3) step(1, 0, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      step(0, i >= 10, 0, 0, 8'(i));
      if (i == 11) check("t1_idle", out_valid, 0);
      if (i == 12) begin
        check("t1_valid", out_valid, 1);
        check("t1_cnt", out_count, 12);
        check("t1_dlt", out_delta, 12);
      end
    end

    // wrap delta: captures at 250 and 4
    repeat (2) step(1, 0, 0, 0, '0);
    for (int i = 240; i < 264; i++)
      step(0, (i == 248) || (i == 258), 0, 0, 8'(i));
    check("wrap_c0", out_count, 250);
    check("wrap_d0", out_delta, 250);
    step(0, 0, 1, 0, '0);
    check("wrap_c1", out_count, 4);
    check("wrap_d1", out_delta, 10);

    // overflow: 5 events, no consumer
    repeat (2) step(1, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++)
      step(0, (i % 3 == 1) && (i < 15), 0, 0, 8'(i + 100));
    check("ovf_lvl", level, 4);
    check("ovf_set", overflow, 1);
    check("ovf_head", out_count, 103);
    step(0, 0, 0, 1, 8'd40);
    check("ovf_clr", overflow, 0);

    // full FIFO: push coincides with pop
    step(0, 1, 0, 0, 8'd50);
    step(0, 0, 0, 0, 8'd51);
    step(0, 0, 1, 0, 8'd52);
    check("fs_lvl", level, 4);
    check("fs_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'd60);
    check("fs_empty", out_valid, 0);

    // backpressure with three queued entries
    repeat (2) step(1, 0, 0, 0, '0);
    for (int i = 0; i < 12; i++)
      step(0, (i % 3 == 1), 0, 0, 8'(7 * i + 3));
    check("bp_lvl", level, 3);
    for (int i = 0; i < 10; i++)
      step(0, 0, i[0], 0, 8'(i));

    // reset with entries queued and event held high
    repeat (2) step(1, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++)
      step(0, (i == 1) || (i == 4), 0, 0, 8'(i + 20));
    step(0, 1, 0, 0, 8'd30);
    step(1, 1, 0, 0, 8'd31);
    check("rst_lvl", level, 0);
    check("rst_vld", out_valid, 0);
    step(1, 1, 0, 0, 8'd32);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'(i + 33));
    check("rst_hold", level, 0);
    step(0, 0, 0, 0, 8'd40);
    step(0, 1, 0, 0, 8'd41);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'(i + 42));
    check("rst_recap", level, 1);

    // random traffic
    rc = '0;
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom % 50 == 0) ? 8'($urandom) : rc + 8'd1;
      step($urandom % 200 == 0, $urandom % 3 == 0,
           $urandom % 2 == 0, $urandom % 16 == 0, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
